// File: rtl/atomrvcore_imem_arbiter.sv
// atomrvcore_imem_arbiter
//   Shares the single instruction-memory port between the fetch unit
//   (read-only) and the loader/debug path (read/write). It keeps at most one
//   transaction in flight and breaks ties round-robin. If memory never
//   answers, a bounded wait ends the transaction with an error response so
//   that fetch cannot hang.
//
// Ports
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   f_req_i, f_addr_i     fetch request/address, held until f_gnt_o
//   f_gnt_o               fetch accepted (1-cycle pulse)
//   f_rvalid_o, f_rdata_o fetch response pulse and held read data
//   f_err_o               fetch response is a timeout error
//   l_req_i, l_we_i,      loader request, write enable, address and
//   l_addr_i, l_wdata_i     write data, held until l_gnt_o
//   l_gnt_o               loader accepted (1-cycle pulse)
//   l_rvalid_o, l_rdata_o loader response pulse (also acks writes), held data
//   l_err_o               loader response is a timeout error
//   m_req_o, m_we_o,      memory request channel, driven only in REQ
//   m_addr_o, m_wdata_o
//   m_gnt_i               memory accepted the request
//   m_rvalid_i, m_rdata_i memory response
//   busy_o                a transaction is in progress (state != IDLE)
module atomrvcore_imem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          f_req_i,
  input  logic [AW-1:0] f_addr_i,
  output logic          f_gnt_o,
  output logic          f_rvalid_o,
  output logic [DW-1:0] f_rdata_o,
  output logic          f_err_o,
  input  logic          l_req_i,
  input  logic          l_we_i,
  input  logic [AW-1:0] l_addr_i,
  input  logic [DW-1:0] l_wdata_i,
  output logic          l_gnt_o,
  output logic          l_rvalid_o,
  output logic [DW-1:0] l_rdata_o,
  output logic          l_err_o,
  output logic          m_req_o,
  output logic          m_we_o,
  output logic [AW-1:0] m_addr_o,
  output logic [DW-1:0] m_wdata_o,
  input  logic          m_gnt_i,
  input  logic          m_rvalid_i,
  input  logic [DW-1:0] m_rdata_i,
  output logic          busy_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic OWN_F = 1'b0;
  localparam logic OWN_L = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q;
  logic            last_owner_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [CW-1:0]   cnt_q;
  logic            f_rvalid_q, f_err_q;
  logic            l_rvalid_q, l_err_q;
  logic [DW-1:0]   f_rdata_q, l_rdata_q;

  logic            sel_loader;
  logic            rsp_ok;
  logic            rsp_tmo;

  // The loader wins when it is the only requester, or on a tie when fetch
  // owned the previous transaction.
  assign sel_loader = l_req_i & (~f_req_i | (last_owner_q == OWN_F));

  // A memory response in the timeout cycle takes precedence over the error.
  assign rsp_ok  = (state_q == S_WAIT) & m_rvalid_i;
  assign rsp_tmo = (state_q == S_WAIT) & ~m_rvalid_i & (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_req_o   = 1'b0;
    m_we_o    = 1'b0;
    m_addr_o  = '0;
    m_wdata_o = '0;
    f_gnt_o   = 1'b0;
    l_gnt_o   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (f_req_i | l_req_i) state_d = S_REQ;
      end
      S_REQ: begin
        m_req_o   = 1'b1;
        m_we_o    = we_q;
        m_addr_o  = addr_q;
        m_wdata_o = wdata_q;
        if (m_gnt_i) begin
          state_d = S_WAIT;
          f_gnt_o = (owner_q == OWN_F);
          l_gnt_o = (owner_q == OWN_L);
        end
      end
      S_WAIT: begin
        if (rsp_ok | rsp_tmo) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q      <= OWN_F;
      last_owner_q <= OWN_L;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      f_rvalid_q   <= 1'b0;
      f_err_q      <= 1'b0;
      l_rvalid_q   <= 1'b0;
      l_err_q      <= 1'b0;
      f_rdata_q    <= '0;
      l_rdata_q    <= '0;
    end else begin
      // Response strobes are single-cycle pulses unless set below.
      f_rvalid_q <= 1'b0;
      f_err_q    <= 1'b0;
      l_rvalid_q <= 1'b0;
      l_err_q    <= 1'b0;

      if ((state_q == S_IDLE) && (f_req_i | l_req_i)) begin
        owner_q <= sel_loader ? OWN_L : OWN_F;
        addr_q  <= sel_loader ? l_addr_i : f_addr_i;
        // Fetch is read-only, so its write fields are forced to zero.
        we_q    <= sel_loader ? l_we_i : 1'b0;
        wdata_q <= sel_loader ? l_wdata_i : '0;
      end

      if ((state_q == S_REQ) && m_gnt_i) begin
        last_owner_q <= owner_q;
        cnt_q        <= '0;
      end

      // Counter is bounded: WAIT is left no later than the CNT_LAST cycle.
      if (state_q == S_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (rsp_ok | rsp_tmo) begin
        if (owner_q == OWN_F) begin
          f_rvalid_q <= 1'b1;
          f_err_q    <= rsp_tmo;
          f_rdata_q  <= rsp_ok ? m_rdata_i : '0;
        end else begin
          l_rvalid_q <= 1'b1;
          l_err_q    <= rsp_tmo;
          l_rdata_q  <= rsp_ok ? m_rdata_i : '0;
        end
      end
    end
  end

  assign f_rvalid_o = f_rvalid_q;
  assign f_err_o    = f_err_q;
  assign f_rdata_o  = f_rdata_q;
  assign l_rvalid_o = l_rvalid_q;
  assign l_err_o    = l_err_q;
  assign l_rdata_o  = l_rdata_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_atomrvcore_imem_arbiter.sv
module tb_atomrvcore_imem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          f_req_i;
  logic [AW-1:0] f_addr_i;
  logic          f_gnt_o;
  logic          f_rvalid_o;
  logic [DW-1:0] f_rdata_o;
  logic          f_err_o;
  logic          l_req_i;
  logic          l_we_i;
  logic [AW-1:0] l_addr_i;
  logic [DW-1:0] l_wdata_i;
  logic          l_gnt_o;
  logic          l_rvalid_o;
  logic [DW-1:0] l_rdata_o;
  logic          l_err_o;
  logic          m_req_o;
  logic          m_we_o;
  logic [AW-1:0] m_addr_o;
  logic [DW-1:0] m_wdata_o;
  logic          m_gnt_i;
  logic          m_rvalid_i;
  logic [DW-1:0] m_rdata_i;
  logic          busy_o;

  int total = 0;
  int bad   = 0;

  atomrvcore_imem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .f_req_i    (f_req_i),
    .f_addr_i   (f_addr_i),
    .f_gnt_o    (f_gnt_o),
    .f_rvalid_o (f_rvalid_o),
    .f_rdata_o  (f_rdata_o),
    .f_err_o    (f_err_o),
    .l_req_i    (l_req_i),
    .l_we_i     (l_we_i),
    .l_addr_i   (l_addr_i),
    .l_wdata_i  (l_wdata_i),
    .l_gnt_o    (l_gnt_o),
    .l_rvalid_o (l_rvalid_o),
    .l_rdata_o  (l_rdata_o),
    .l_err_o    (l_err_o),
    .m_req_o    (m_req_o),
    .m_we_o     (m_we_o),
    .m_addr_o   (m_addr_o),
    .m_wdata_o  (m_wdata_o),
    .m_gnt_i    (m_gnt_i),
    .m_rvalid_i (m_rvalid_i),
    .m_rdata_i  (m_rdata_i),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge; inputs set afterwards apply
  // to the following edge, and outputs are sampled #1 later.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle_inputs();
    f_req_i    = 1'b0;
    f_addr_i   = '0;
    l_req_i    = 1'b0;
    l_we_i     = 1'b0;
    l_addr_i   = '0;
    l_wdata_i  = '0;
    m_gnt_i    = 1'b0;
    m_rvalid_i = 1'b0;
    m_rdata_i  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if ({m_req_o, m_we_o, f_gnt_o, l_gnt_o, f_rvalid_o, f_err_o, l_rvalid_o, l_err_o, busy_o} !== 9'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 000000000",
               {m_req_o, m_we_o, f_gnt_o, l_gnt_o, f_rvalid_o, f_err_o, l_rvalid_o, l_err_o, busy_o});
    end
    total++;
    if ({m_addr_o, m_wdata_o, f_rdata_o, l_rdata_o} !== 128'h0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", {m_addr_o, m_wdata_o, f_rdata_o, l_rdata_o});
    end
  endtask

  task automatic test_single_fetch();
    do_reset();
    f_req_i  = 1'b1;
    f_addr_i = 32'h100;
    m_gnt_i  = 1'b1;
    tick();                              // cycle 1: REQ
    #1;
    total++;
    if ({m_req_o, m_we_o, f_gnt_o, l_gnt_o, busy_o} !== 5'b10101 || m_addr_o !== 32'h100 || m_wdata_o !== 32'h0) begin
      bad++;
      $display("FAIL single_req: ctl=%b addr=%h wdata=%h want ctl=10101 addr=00000100 wdata=0",
               {m_req_o, m_we_o, f_gnt_o, l_gnt_o, busy_o}, m_addr_o, m_wdata_o);
    end
    f_req_i = 1'b0;
    tick();                              // cycle 2: WAIT
    m_rvalid_i = 1'b1;
    m_rdata_i  = 32'h00500093;
    #1;
    total++;
    if ({m_req_o, f_gnt_o, f_rvalid_o, busy_o} !== 4'b0001) begin
      bad++;
      $display("FAIL single_wait: got %b want 0001", {m_req_o, f_gnt_o, f_rvalid_o, busy_o});
    end
    tick();                              // cycle 3: response
    m_rvalid_i = 1'b0;
    m_rdata_i  = '0;
    #1;
    total++;
    if ({f_rvalid_o, f_err_o, busy_o} !== 3'b100 || f_rdata_o !== 32'h00500093) begin
      bad++;
      $display("FAIL single_rsp: ctl=%b rdata=%h want ctl=100 rdata=00500093",
               {f_rvalid_o, f_err_o, busy_o}, f_rdata_o);
    end
    total++;
    if ({l_gnt_o, l_rvalid_o, l_err_o} !== 3'b0 || l_rdata_o !== 32'h0) begin
      bad++;
      $display("FAIL single_loader_quiet: ctl=%b rdata=%h want 0",
               {l_gnt_o, l_rvalid_o, l_err_o}, l_rdata_o);
    end
    tick();
    #1;
    total++;
    if ({f_rvalid_o, f_rdata_o} !== {1'b0, 32'h00500093}) begin
      bad++;
      $display("FAIL single_hold: rvalid=%b rdata=%h want 0/00500093", f_rvalid_o, f_rdata_o);
    end
  endtask

  task automatic test_round_robin();
    logic          exp_l;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [DW-1:0] rd;
    do_reset();
    f_req_i   = 1'b1;
    f_addr_i  = 32'h300;
    l_req_i   = 1'b1;
    l_we_i    = 1'b1;
    l_addr_i  = 32'h200;
    l_wdata_i = 32'hDEADBEEF;
    m_gnt_i   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_l     = (i % 2 == 1);
      exp_addr  = exp_l ? 32'h200 : 32'h300;
      exp_wdata = exp_l ? 32'hDEADBEEF : 32'h0;
      rd        = 32'hA0000000 + i;
      tick();                            // REQ
      #1;
      total++;
      if ({m_req_o, m_we_o, f_gnt_o, l_gnt_o} !== {1'b1, exp_l, ~exp_l, exp_l} ||
          m_addr_o !== exp_addr || m_wdata_o !== exp_wdata) begin
        bad++;
        $display("FAIL rr_grant%0d: ctl=%b addr=%h wdata=%h want ctl=%b addr=%h wdata=%h", i,
                 {m_req_o, m_we_o, f_gnt_o, l_gnt_o}, m_addr_o, m_wdata_o,
                 {1'b1, exp_l, ~exp_l, exp_l}, exp_addr, exp_wdata);
      end
      tick();                            // WAIT
      m_rvalid_i = 1'b1;
      m_rdata_i  = rd;
      #1;
      total++;
      if ({m_req_o, m_we_o, m_addr_o, m_wdata_o} !== 66'h0) begin
        bad++;
        $display("FAIL rr_wait_quiet%0d: req=%b we=%b addr=%h wdata=%h want all 0", i,
                 m_req_o, m_we_o, m_addr_o, m_wdata_o);
      end
      tick();                            // response, next request latched
      m_rvalid_i = 1'b0;
      m_rdata_i  = '0;
      #1;
      total++;
      if ({f_rvalid_o, l_rvalid_o, f_err_o, l_err_o} !== {~exp_l, exp_l, 2'b00} ||
          (exp_l ? l_rdata_o : f_rdata_o) !== rd) begin
        bad++;
        $display("FAIL rr_rsp%0d: ctl=%b f_rdata=%h l_rdata=%h want ctl=%b data=%h", i,
                 {f_rvalid_o, l_rvalid_o, f_err_o, l_err_o}, f_rdata_o, l_rdata_o,
                 {~exp_l, exp_l, 2'b00}, rd);
      end
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    f_req_i  = 1'b1;
    f_addr_i = 32'h400;
    m_gnt_i  = 1'b0;
    tick();                              // first REQ cycle
    for (int i = 0; i < 6; i++) begin
      m_gnt_i = (i == 5);
      #1;
      total++;
      if ({m_req_o, f_gnt_o, l_gnt_o} !== {1'b1, (i == 5), 1'b0} || m_addr_o !== 32'h400) begin
        bad++;
        $display("FAIL bp_cycle%0d: ctl=%b addr=%h want ctl=%b addr=00000400", i,
                 {m_req_o, f_gnt_o, l_gnt_o}, m_addr_o, {1'b1, (i == 5), 1'b0});
      end
      tick();
    end
    f_req_i    = 1'b0;
    m_rvalid_i = 1'b1;
    m_rdata_i  = 32'h13579BDF;
    tick();
    m_rvalid_i = 1'b0;
    #1;
    total++;
    if ({f_rvalid_o, f_err_o} !== 2'b10 || f_rdata_o !== 32'h13579BDF) begin
      bad++;
      $display("FAIL bp_rsp: ctl=%b rdata=%h want 10/13579bdf", {f_rvalid_o, f_err_o}, f_rdata_o);
    end
    tick();
  endtask

  // collide=1 drives m_rvalid_i in the cycle the counter reaches TIMEOUT-1.
  task automatic test_timeout(input logic collide);
    logic seen;
    do_reset();
    // Prime f_rdata_o with a non-zero value so the error zeroing is visible.
    f_req_i = 1'b1;
    m_gnt_i = 1'b1;
    f_addr_i = 32'h480;
    tick();
    f_req_i = 1'b0;
    tick();
    m_rvalid_i = 1'b1;
    m_rdata_i  = 32'h00001234;
    tick();
    m_rvalid_i = 1'b0;
    m_rdata_i  = '0;
    f_req_i    = 1'b1;
    f_addr_i   = 32'h500;
    tick();                              // grant cycle G
    #1;
    total++;
    if (f_gnt_o !== 1'b1) begin
      bad++;
      $display("FAIL tmo_grant%0d: f_gnt=%b want 1", collide, f_gnt_o);
    end
    f_req_i = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      if (collide && k == TIMEOUT) begin
        m_rvalid_i = 1'b1;
        m_rdata_i  = 32'hCAFE0001;
      end
      #1;
      if (f_rvalid_o !== 1'b0 || busy_o !== 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL tmo_early%0d: rvalid or idle seen before cycle %0d, want none", collide, TIMEOUT + 1);
    end
    tick();                              // cycle G+TIMEOUT+1
    m_rvalid_i = 1'b0;
    m_rdata_i  = '0;
    #1;
    total++;
    if ({f_rvalid_o, f_err_o, busy_o, l_rvalid_o} !== {1'b1, ~collide, 2'b00} ||
        f_rdata_o !== (collide ? 32'hCAFE0001 : 32'h0)) begin
      bad++;
      $display("FAIL tmo_rsp%0d: ctl=%b rdata=%h want ctl=%b rdata=%h", collide,
               {f_rvalid_o, f_err_o, busy_o, l_rvalid_o}, f_rdata_o,
               {1'b1, ~collide, 2'b00}, (collide ? 32'hCAFE0001 : 32'h0));
    end
    if (!collide) begin
      m_rvalid_i = 1'b1;
      m_rdata_i  = 32'h00000BAD;
      tick();
      m_rvalid_i = 1'b0;
      m_rdata_i  = '0;
      #1;
      total++;
      if ({f_rvalid_o, l_rvalid_o, busy_o} !== 3'b0 || f_rdata_o !== 32'h0) begin
        bad++;
        $display("FAIL tmo_late: ctl=%b rdata=%h want 000/0", {f_rvalid_o, l_rvalid_o, busy_o}, f_rdata_o);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    f_req_i  = 1'b1;
    f_addr_i = 32'h600;
    m_gnt_i  = 1'b1;
    tick();                              // REQ, fetch granted
    f_req_i = 1'b0;
    tick();                              // WAIT
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    total++;
    if ({m_req_o, m_we_o, f_gnt_o, l_gnt_o, f_rvalid_o, f_err_o, l_rvalid_o, l_err_o, busy_o} !== 9'b0 ||
        {m_addr_o, m_wdata_o, f_rdata_o, l_rdata_o} !== 128'h0) begin
      bad++;
      $display("FAIL rst_wait_outputs: ctl=%b data=%h want all 0",
               {m_req_o, m_we_o, f_gnt_o, l_gnt_o, f_rvalid_o, f_err_o, l_rvalid_o, l_err_o, busy_o},
               {m_addr_o, m_wdata_o, f_rdata_o, l_rdata_o});
    end
    m_rvalid_i = 1'b1;
    m_rdata_i  = 32'h77777777;
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      total++;
      if ({f_rvalid_o, l_rvalid_o, busy_o} !== 3'b0 || f_rdata_o !== 32'h0) begin
        bad++;
        $display("FAIL rst_wait_late%0d: ctl=%b rdata=%h want 000/0", i,
                 {f_rvalid_o, l_rvalid_o, busy_o}, f_rdata_o);
      end
    end
    m_rvalid_i = 1'b0;
    m_rdata_i  = '0;
    // Tie after reset must go to fetch even though fetch owned the aborted one.
    f_req_i   = 1'b1;
    f_addr_i  = 32'h700;
    l_req_i   = 1'b1;
    l_addr_i  = 32'h800;
    tick();
    #1;
    total++;
    if ({f_gnt_o, l_gnt_o} !== 2'b10 || m_addr_o !== 32'h700) begin
      bad++;
      $display("FAIL rst_wait_tie: gnt=%b addr=%h want 10/00000700", {f_gnt_o, l_gnt_o}, m_addr_o);
    end
    idle_inputs();
    tick();
    m_rvalid_i = 1'b1;
    tick();
    m_rvalid_i = 1'b0;
    tick();
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_backpressure();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
